// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter: packs up to two accepted writeback requests per cycle
// onto the register file's two write ports, with x0 writes retired without using a port.
module rf_wb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] src_wdata,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      we1,
  output logic [ADDR_W-1:0]         waddr1,
  output logic [DATA_W-1:0]         wdata1,
  output logic                      we2,
  output logic [ADDR_W-1:0]         waddr2,
  output logic [DATA_W-1:0]         wdata2
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0] NUM_SRC_W = (PTR_W + 1)'(NUM_SRC);

  logic [ADDR_W-1:0] addr_arr [NUM_SRC];
  logic [DATA_W-1:0] data_arr [NUM_SRC];

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign addr_arr[gi] = src_waddr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = src_wdata[gi*DATA_W +: DATA_W];
  end

  logic [PTR_W-1:0]  rr_ptr_reg;
  logic [PTR_W-1:0]  rr_ptr_next;
  logic              we1_reg;
  logic              we2_reg;
  logic [ADDR_W-1:0] waddr1_reg;
  logic [ADDR_W-1:0] waddr2_reg;
  logic [DATA_W-1:0] wdata1_reg;
  logic [DATA_W-1:0] wdata2_reg;

  logic              grant1;
  logic              grant2;
  logic [PTR_W-1:0]  idx1;
  logic [PTR_W-1:0]  idx2;
  logic [ADDR_W-1:0] addr1;
  logic [PTR_W:0]    pos_sum;
  logic [PTR_W-1:0]  pos_idx;
  logic [PTR_W:0]    next_sum;

  // Scan sources starting at rr_ptr; x0 writes are acked without touching port state.
  always_comb begin
    src_ready = '0;
    grant1    = 1'b0;
    grant2    = 1'b0;
    idx1      = '0;
    idx2      = '0;
    addr1     = '0;
    pos_sum   = '0;
    pos_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos_sum = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(k);
      if (pos_sum >= NUM_SRC_W) begin
        pos_sum = pos_sum - NUM_SRC_W;
      end
      pos_idx = pos_sum[PTR_W-1:0];
      if (src_valid[pos_idx]) begin
        if (addr_arr[pos_idx] == '0) begin
          src_ready[pos_idx] = 1'b1;
        end else if (!grant1) begin
          grant1             = 1'b1;
          idx1               = pos_idx;
          addr1              = addr_arr[pos_idx];
          src_ready[pos_idx] = 1'b1;
        end else if (!grant2 && (addr_arr[pos_idx] != addr1)) begin
          grant2             = 1'b1;
          idx2               = pos_idx;
          src_ready[pos_idx] = 1'b1;
        end
      end
    end
  end

  // Priority moves to just past the last source that won a port.
  always_comb begin
    next_sum    = '0;
    rr_ptr_next = rr_ptr_reg;
    if (grant2) begin
      next_sum = {1'b0, idx2} + 1'b1;
    end else if (grant1) begin
      next_sum = {1'b0, idx1} + 1'b1;
    end
    if (grant1) begin
      if (next_sum >= NUM_SRC_W) begin
        next_sum = next_sum - NUM_SRC_W;
      end
      rr_ptr_next = next_sum[PTR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_reg <= '0;
      we1_reg    <= 1'b0;
      we2_reg    <= 1'b0;
      waddr1_reg <= '0;
      waddr2_reg <= '0;
      wdata1_reg <= '0;
      wdata2_reg <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      we1_reg    <= grant1;
      we2_reg    <= grant2;
      // Address/data hold when a port is idle; only the enable clears.
      if (grant1) begin
        waddr1_reg <= addr_arr[idx1];
        wdata1_reg <= data_arr[idx1];
      end
      if (grant2) begin
        waddr2_reg <= addr_arr[idx2];
        wdata2_reg <= data_arr[idx2];
      end
    end
  end

  assign we1    = we1_reg;
  assign we2    = we2_reg;
  assign waddr1 = waddr1_reg;
  assign waddr2 = waddr2_reg;
  assign wdata1 = wdata1_reg;
  assign wdata2 = wdata2_reg;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (4 sources, 5-bit address, 32-bit data).
module tb_rf_wb_arbiter;

  localparam int NUM_SRC = 4;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*ADDR_W-1:0] src_waddr;
  logic [NUM_SRC*DATA_W-1:0] src_wdata;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      we1;
  logic [ADDR_W-1:0]         waddr1;
  logic [DATA_W-1:0]         wdata1;
  logic                      we2;
  logic [ADDR_W-1:0]         waddr2;
  logic [DATA_W-1:0]         wdata2;

  int checks;
  int failures;

  rf_wb_arbiter #(.NUM_SRC(NUM_SRC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_waddr(src_waddr), .src_wdata(src_wdata),
    .src_ready(src_ready),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    src_valid[i]                = v;
    src_waddr[i*ADDR_W +: ADDR_W] = a;
    src_wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    src_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    src_valid = '0;
    src_waddr = 20'hABCDE;
    src_wdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({we1, we2, waddr1, waddr2, wdata1, wdata2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b%b a=%0d/%0d d=%h/%h want all 0",
               we1, we2, waddr1, waddr2, wdata1, wdata2);
    end
    tick();
    checks++;
    if ({we1, we2, waddr1, wdata1} !== '0) begin
      failures++;
      $display("FAIL reset_held: got we1=%b we2=%b want 0", we1, we2);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (src_ready !== 4'b0000) begin
        failures++;
        $display("FAIL idle_ready cyc%0d: got %b want 0000", c, src_ready);
      end
      tick();
      checks++;
      if ({we1, we2} !== 2'b00) begin
        failures++;
        $display("FAIL idle_we cyc%0d: got we1=%b we2=%b want 0 0", c, we1, we2);
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_dual_grant();
    do_reset();
    set_src(0, 1'b1, 5'd3, 32'h11);
    set_src(2, 1'b1, 5'd7, 32'h22);
    #1;
    checks++;
    if (src_ready !== 4'b0101) begin
      failures++;
      $display("FAIL dual_ready: got %b want 0101", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({we1, waddr1, wdata1, we2, waddr2, wdata2} !== {1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22}) begin
      failures++;
      $display("FAIL dual_out: got we1=%b a1=%0d d1=%h we2=%b a2=%0d d2=%h want 1 3 11 1 7 22",
               we1, waddr1, wdata1, we2, waddr2, wdata2);
    end
    // rr_ptr is now 3: scan 3,0,1 gives source 1 port 1; port 2 must hold 7/0x22
    set_src(1, 1'b1, 5'd4, 32'h44);
    set_src(3, 1'b1, 5'd0, 32'h99);
    #1;
    checks++;
    if (src_ready !== 4'b1010) begin
      failures++;
      $display("FAIL hold_ready: got %b want 1010", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({we1, waddr1, wdata1, we2, waddr2, wdata2} !== {1'b1, 5'd4, 32'h44, 1'b0, 5'd7, 32'h22}) begin
      failures++;
      $display("FAIL hold_out: got we1=%b a1=%0d d1=%h we2=%b a2=%0d d2=%h want 1 4 44 0 7 22",
               we1, waddr1, wdata1, we2, waddr2, wdata2);
    end
    $display("test_dual_grant done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_same_addr();
    do_reset();
    set_src(0, 1'b1, 5'd5, 32'hA0A0);
    set_src(1, 1'b1, 5'd5, 32'hB1B1);
    #1;
    checks++;
    if (src_ready !== 4'b0001) begin
      failures++;
      $display("FAIL conflict_ready: got %b want 0001", src_ready);
    end
    tick();
    src_valid[0] = 1'b0;
    checks++;
    if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd5, 32'hA0A0, 1'b0}) begin
      failures++;
      $display("FAIL conflict_out: got we1=%b a1=%0d d1=%h we2=%b want 1 5 a0a0 0",
               we1, waddr1, wdata1, we2);
    end
    #1;
    checks++;
    if (src_ready !== 4'b0010) begin
      failures++;
      $display("FAIL retry_ready: got %b want 0010", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd5, 32'hB1B1, 1'b0}) begin
      failures++;
      $display("FAIL retry_out: got we1=%b a1=%0d d1=%h we2=%b want 1 5 b1b1 0",
               we1, waddr1, wdata1, we2);
    end
    $display("test_same_addr done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_x0_retire();
    do_reset();
    set_src(1, 1'b1, 5'd0, 32'hDEAD);
    set_src(3, 1'b1, 5'd9, 32'h9999);
    #1;
    checks++;
    if (src_ready !== 4'b1010) begin
      failures++;
      $display("FAIL x0_ready: got %b want 1010", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({we1, waddr1, wdata1, we2} !== {1'b1, 5'd9, 32'h9999, 1'b0}) begin
      failures++;
      $display("FAIL x0_out: got we1=%b a1=%0d d1=%h we2=%b want 1 9 9999 0",
               we1, waddr1, wdata1, we2);
    end
    // rr_ptr back to 0 means source 0 outranks source 3
    set_src(0, 1'b1, 5'd1, 32'h0A);
    set_src(3, 1'b1, 5'd2, 32'h0B);
    tick();
    src_valid = '0;
    checks++;
    if ({waddr1, wdata1, waddr2, wdata2} !== {5'd1, 32'h0A, 5'd2, 32'h0B}) begin
      failures++;
      $display("FAIL x0_ptr: got a1=%0d d1=%h a2=%0d d2=%h want 1 a 2 b",
               waddr1, wdata1, waddr2, wdata2);
    end
    $display("test_x0_retire done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_ready [4] = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    logic [4:0]  exp_a1    [4] = '{5'd1, 5'd3, 5'd1, 5'd3};
    logic [4:0]  exp_a2    [4] = '{5'd2, 5'd4, 5'd2, 5'd4};
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      set_src(i, 1'b1, 5'(i + 1), 32'(32'h100 * (i + 1)));
    end
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (src_ready !== exp_ready[c]) begin
        failures++;
        $display("FAIL fair_ready cyc%0d: got %b want %b", c, src_ready, exp_ready[c]);
      end
      tick();
      checks++;
      if ({we1, waddr1, we2, waddr2} !== {1'b1, exp_a1[c], 1'b1, exp_a2[c]}) begin
        failures++;
        $display("FAIL fair_out cyc%0d: got we1=%b a1=%0d we2=%b a2=%0d want 1 %0d 1 %0d",
                 c, we1, waddr1, we2, waddr2, exp_a1[c], exp_a2[c]);
      end
    end
    src_valid = '0;
    $display("test_fairness done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_async_reset();
    do_reset();
    set_src(1, 1'b1, 5'd6, 32'h66);
    set_src(2, 1'b1, 5'd8, 32'h88);
    tick();
    src_valid = '0;
    checks++;
    if ({we1, we2} !== 2'b11) begin
      failures++;
      $display("FAIL async_pre: got we1=%b we2=%b want 1 1", we1, we2);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({we1, we2, waddr1, waddr2, wdata1, wdata2} !== '0) begin
      failures++;
      $display("FAIL async_clear: got we=%b%b a=%0d/%0d d=%h/%h want all 0",
               we1, we2, waddr1, waddr2, wdata1, wdata2);
    end
    @(negedge clk);
    rst = 1'b1;
    set_src(0, 1'b1, 5'd1, 32'hA);
    set_src(3, 1'b1, 5'd2, 32'hB);
    #1;
    checks++;
    if (src_ready !== 4'b1001) begin
      failures++;
      $display("FAIL async_restart_ready: got %b want 1001", src_ready);
    end
    tick();
    src_valid = '0;
    checks++;
    if ({waddr1, wdata1, waddr2, wdata2} !== {5'd1, 32'hA, 5'd2, 32'hB}) begin
      failures++;
      $display("FAIL async_restart_out: got a1=%0d d1=%h a2=%0d d2=%h want 1 a 2 b",
               waddr1, wdata1, waddr2, wdata2);
    end
    $display("test_async_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    src_valid = '0;
    src_waddr = '0;
    src_wdata = '0;
    test_reset();
    test_dual_grant();
    test_same_addr();
    test_x0_retire();
    test_fairness();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's two write ports (we1/waddr1/wdata1, we2/waddr2/wdata2) among NUM_SRC writeback sources, e.g. ALU0, ALU1, LSU and MUL/DIV.
- Per-source valid/ready handshake with round-robin priority.
- Resolves same-destination conflicts within a cycle and silently retires writes to x0.
- The write-port outputs are registered, so the block sits between the execution-unit writeback buses and the register file.

Parameters:
- NUM_SRC, 4, number of writeback requesters (2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- src_valid  input  NUM_SRC  per-source write request.
- src_waddr  input  NUM_SRC*ADDR_W  packed destination addresses; source i occupies [i*ADDR_W +: ADDR_W].
- src_wdata  input  NUM_SRC*DATA_W  packed write data; source i occupies [i*DATA_W +: DATA_W].
- src_ready  output  NUM_SRC  per-source accept, combinational.
- we1  output  1  RF write port 1 enable, registered.
- waddr1  output  ADDR_W  RF write port 1 address, registered.
- wdata1  output  DATA_W  RF write port 1 data, registered.
- we2  output  1  RF write port 2 enable, registered.
- waddr2  output  ADDR_W  RF write port 2 address, registered.
- wdata2  output  DATA_W  RF write port 2 data, registered.

Behaviour:
- Handshake:
  - A transfer occurs on a rising clk edge when src_valid[i] and src_ready[i] are both 1.
  - A source holds valid, waddr and wdata stable until accepted.
  - src_ready[i] is 0 whenever src_valid[i] is 0.
- Scan order:
  - State: rr_ptr, log2(NUM_SRC) bits, reset 0.
  - Each cycle, sources are examined in order k = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC.
- x0 handling:
  - A valid source with waddr == 0 gets ready = 1 unconditionally.
  - It consumes no port and does not affect rr_ptr or the conflict check.
- Port 1: the first valid source in scan order with waddr != 0 gets ready = 1 and is assigned port 1.
- Port 2: the next valid source in scan order with waddr != 0 and waddr != the port-1 waddr gets ready = 1 and is assigned port 2.
- Losers: every other valid nonzero-address source gets ready = 0 and retries next cycle.
  - This includes same-address losers; it guarantees the RF never sees two writes to one register in one cycle.
- Output register:
  - On the clock edge, we1 takes 1 if port 1 was assigned, else 0; waddr1/wdata1 take the granted source's values.
  - Port 2 behaves identically.
  - When a port is not granted, its waddr and wdata hold their previous values; only the we bit clears.
  - Latency from accept to RF write enable is exactly 1 cycle; throughput is up to 2 RF writes per cycle.
- rr_ptr update:
  - After any port grant, rr_ptr becomes (index of the last port-granted source + 1) mod NUM_SRC.
  - With no port grant, rr_ptr is unchanged.
  - Guarantees starvation-freedom: a continuously valid source is granted within ceil(NUM_SRC/2) cycles, absent a same-address conflict with a higher-priority source.
- Port ordering: port 1 always carries the higher-priority grant. If only one grant occurs, it is on port 1 and we2 = 0.
- Reset (rst low, asynchronous):
  - we1, we2, waddr1, waddr2, wdata1, wdata2 and rr_ptr go to 0 immediately.
  - src_ready follows the combinational rules above and is not gated by reset; sources must hold valid low during reset.
  - Reset mid-operation discards any registered but not yet written entry, since the outputs clear.
- All-idle: with no valid inputs, src_ready = 0, and on the next edge we1 = we2 = 0.
- Scope: no internal buffering beyond the single output register stage.
- Ordering between sources is not the block's responsibility: the issue logic guarantees that no two in-flight instructions target the same register out of order.

Test Plan:
- Reset: drive rst low with arbitrary inputs -> all outputs 0, rr_ptr 0. Release; src_valid = 0 -> we1 = we2 = 0 on every edge.
- Dual grant: rr_ptr = 0; sources 0 and 2 valid with waddr 3/7, wdata 0x11/0x22 -> src_ready = 0101. Next cycle: we1 = 1, waddr1 = 3, wdata1 = 0x11; we2 = 1, waddr2 = 7, wdata2 = 0x22. rr_ptr = 3.
- Same-address conflict: sources 0 and 1 both valid, waddr 5, rr_ptr = 0 -> ready = 0001, we1 = 1, we2 = 0, rr_ptr = 1. Next cycle, source 1 alone -> ready = 0010, we1 = 1, waddr1 = 5, data from source 1.
- x0 retire: source 1 valid, waddr 0; source 3 valid, waddr 9 -> ready = 1010, we1 = 1, waddr1 = 9, we2 = 0, rr_ptr = 0.
- Fairness: all four sources continuously valid with distinct addresses for 4 cycles from rr_ptr = 0 -> grants {0,1}, {2,3}, {0,1}, {2,3}; each source accepted every second cycle.
- Asynchronous reset mid-stream: assert rst low between edges while we1 = we2 = 1 -> outputs drop to 0 immediately, without waiting for clk. After release, arbitration restarts from rr_ptr = 0.
